operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_W, 64, operand/data width.
REQ-002 Parameter ADDR_W, 5, register address width (32 registers).
REQ-003 Parameter ZERO_REG, 31, register that always reads 0 and is never tracked as pending.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  decoded instruction present.
REQ-007 in_ready  out  1  stage accepts instruction this cycle.
REQ-008 in_sa, in_sb  in  ADDR_W  source register addresses.
REQ-009 in_da  in  ADDR_W  destination register address.
REQ-010 in_regWrite  in  1  instruction will write in_da.
REQ-011 in_imm  in  DATA_W  immediate; in_useImm  in  1  selects in_imm for operand B.
REQ-012 rdAddrA, rdAddrB  out  ADDR_W  register-file read addresses (combinational, = in_sa/in_sb).
REQ-013 rdDataA, rdDataB  in  DATA_W  register-file read data (combinational read).
REQ-014 wb_write  in  1; wb_addr  in  ADDR_W; wb_data  in  DATA_W  writeback port, also driving the register-file write port.
REQ-015 out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-016 out_a, out_b  out  DATA_W; out_da  out  ADDR_W; out_regWrite  out  1  registered issued operands.

Function
REQ-017 A 32-bit pending scoreboard SHALL mark registers with an issued, not-yet-written-back result.
REQ-018 Source operand X SHALL be hazardous when pending[X] is set and not (wb_write and wb_addr == X); B-source check SHALL be skipped when in_useImm=1.
REQ-019 WAW hazard SHALL exist when in_regWrite=1 and pending[in_da] is set and not cleared by same-cycle writeback.
REQ-020 in_ready SHALL equal (no hazard) and (out_valid=0 or out_ready=1); issue occurs when in_valid and in_ready.
REQ-021 Operand value SHALL be 0 for ZERO_REG, else wb_data when wb_write and wb_addr matches, else rdData (bypass priority in that order).
REQ-022 On issue, out_a/out_b/out_da/out_regWrite SHALL load next edge and out_valid SHALL be 1; latency 1 cycle.
REQ-023 When out_valid=1 and out_ready=0, output registers SHALL hold stable.
REQ-024 When out_ready=1 and no issue, out_valid SHALL clear next edge.
REQ-025 On issue with in_regWrite=1 and in_da != ZERO_REG, pending[in_da] SHALL set.
REQ-026 wb_write=1 SHALL clear pending[wb_addr]; a simultaneous issue setting the same bit SHALL win (bit ends set).
REQ-027 pending[ZERO_REG] SHALL remain 0 always; wb_write to ZERO_REG has no scoreboard effect.
REQ-028 in_ready SHALL depend combinationally on wb signals but never on in_valid.

Reset
REQ-029 reset=1 SHALL clear out_valid, out_regWrite, all pending bits, and zero out_a, out_b, out_da next edge.
REQ-030 reset mid-stall SHALL discard the held instruction; in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-031 DATA_W, ADDR_W, ZERO_REG defaults SHALL live in the shared cpu package.
REQ-032 Scoreboard SHALL be one sub-module, scoreboard32 (set/clear ports, pending vector output).

Verification
REQ-033 reset, then issue sa=1 sb=2 da=3 regWrite with rdDataA=5, rdDataB=7 -> next cycle out_valid=1, out_a=5, out_b=7, pending[3]=1.
REQ-034 issue reading sa=3 while pending[3] set, no wb -> in_ready=0; assert wb_write addr=3 data=0xAAAA -> in_ready=1, out_a=0xAAAA next edge.
REQ-035 sa=31, rdDataA=0xFFFF -> out_a=0; issue da=31 regWrite -> pending stays all-zero.
REQ-036 out_ready=0 with out_valid=1, new in_valid -> in_ready=0, outputs unchanged; out_ready=1 -> new instruction issues same cycle.
REQ-037 wb_write addr=4 and issue da=4 same cycle with pending[4]=1 -> pending[4]=1 after edge.
REQ-038 reset during stall with pending[3]=1 -> out_valid=0, pending all-zero, in_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU parameters and types for the operand-fetch stage and its scoreboard.
package cpu_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 5;
  localparam int ZERO_REG_DEF = 31;
  localparam int NUM_REGS     = 32;

  typedef logic [NUM_REGS-1:0] pending_t;

  // True when a writeback is writing the register being looked up this cycle.
  function automatic logic wb_hit(input logic wr, input logic [ADDR_W_DEF-1:0] wa,
                                  input logic [ADDR_W_DEF-1:0] ra);
    wb_hit = wr && (wa == ra);
  endfunction

endpackage

// File: rtl/scoreboard32.sv
// Pending-write scoreboard: one bit per register, set on issue and cleared on writeback.
module scoreboard32
  import cpu_pkg::*;
#(
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [ADDR_W_DEF-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_W_DEF-1:0] clr_addr,
  output pending_t              pending
);

  pending_t pending_q;
  pending_t pending_d;

  // Set is applied after clear so a same-cycle issue to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_addr] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (set_en) begin
      pending_d[set_addr] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: hazard check against the scoreboard, writeback bypass,
// and a single registered output slot with valid/ready handshake.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_sa,
  input  logic [ADDR_W-1:0] in_sb,
  input  logic [ADDR_W-1:0] in_da,
  input  logic              in_regWrite,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_useImm,
  output logic [ADDR_W-1:0] rdAddrA,
  output logic [ADDR_W-1:0] rdAddrB,
  input  logic [DATA_W-1:0] rdDataA,
  input  logic [DATA_W-1:0] rdDataB,
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ADDR_W-1:0] out_da,
  output logic              out_regWrite
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  pending_t          pending;
  logic              haz_a;
  logic              haz_b;
  logic              haz_waw;
  logic              issue;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic [ADDR_W-1:0] out_da_q, out_da_d;
  logic              out_regWrite_q, out_regWrite_d;

  function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] addr,
                                            input logic [DATA_W-1:0] rd);
    if (addr == ZERO_A) begin
      fwd = '0;
    end else if (wb_hit(wb_write, wb_addr, addr)) begin
      fwd = wb_data;
    end else begin
      fwd = rd;
    end
  endfunction

  assign rdAddrA = in_sa;
  assign rdAddrB = in_sb;

  // A same-cycle writeback resolves the hazard, so in_ready follows wb_* but not in_valid.
  always_comb begin
    haz_a    = pending[in_sa] && !wb_hit(wb_write, wb_addr, in_sa);
    haz_b    = !in_useImm && pending[in_sb] && !wb_hit(wb_write, wb_addr, in_sb);
    haz_waw  = in_regWrite && pending[in_da] && !wb_hit(wb_write, wb_addr, in_da);
    in_ready = !(haz_a || haz_b || haz_waw) && (!out_valid_q || out_ready);
    issue    = in_valid && in_ready;
    opnd_a   = fwd(in_sa, rdDataA);
    if (in_useImm) begin
      opnd_b = in_imm;
    end else begin
      opnd_b = fwd(in_sb, rdDataB);
    end
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_a_d        = out_a_q;
    out_b_d        = out_b_q;
    out_da_d       = out_da_q;
    out_regWrite_d = out_regWrite_q;
    if (issue) begin
      out_valid_d    = 1'b1;
      out_a_d        = opnd_a;
      out_b_d        = opnd_b;
      out_da_d       = in_da;
      out_regWrite_d = in_regWrite;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_a_q        <= '0;
      out_b_q        <= '0;
      out_da_q       <= '0;
      out_regWrite_q <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_a_q        <= out_a_d;
      out_b_q        <= out_b_d;
      out_da_q       <= out_da_d;
      out_regWrite_q <= out_regWrite_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_a        = out_a_q;
  assign out_b        = out_b_q;
  assign out_da       = out_da_q;
  assign out_regWrite = out_regWrite_q;

  scoreboard32 #(.ZERO_REG(ZERO_REG)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (issue && in_regWrite && (in_da != ZERO_A)),
    .set_addr (in_da),
    .clr_en   (wb_write),
    .clr_addr (wb_addr),
    .pending  (pending)
  );

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard-driven bench for operand_fetch: a reference model predicts in_ready,
// pending bits and the issued operands, which are queued and compared at the output.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_regWrite, in_useImm;
  logic [4:0]  in_sa, in_sb, in_da, rdAddrA, rdAddrB, wb_addr, out_da;
  logic [63:0] in_imm, rdDataA, rdDataB, wb_data, out_a, out_b;
  logic        wb_write, out_valid, out_ready, out_regWrite;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  da;
    logic        rw;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] m_pend = 32'd0;
  logic        m_valid = 1'b0;
  int          n_checks = 0;
  int          n_fails = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sa(in_sa), .in_sb(in_sb), .in_da(in_da), .in_regWrite(in_regWrite),
    .in_imm(in_imm), .in_useImm(in_useImm), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
    .rdDataA(rdDataA), .rdDataB(rdDataB), .wb_write(wb_write), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_b(out_b), .out_da(out_da), .out_regWrite(out_regWrite)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic hit(input logic [4:0] a);
    return wb_write && (wb_addr == a);
  endfunction

  function automatic logic [63:0] model_opnd(input logic [4:0] a, input logic [63:0] rd);
    if (a == 5'd31) return 64'd0;
    if (hit(a)) return wb_data;
    return rd;
  endfunction

  task automatic set_in(input logic v, input logic [4:0] sa, input logic [4:0] sb,
                        input logic [4:0] da, input logic rw, input logic ui,
                        input logic [63:0] imm);
    in_valid = v; in_sa = sa; in_sb = sb; in_da = da;
    in_regWrite = rw; in_useImm = ui; in_imm = imm;
  endtask

  task automatic set_wb(input logic w, input logic [4:0] a, input logic [63:0] d);
    wb_write = w; wb_addr = a; wb_data = d;
  endtask

  // One clock: predict and check in_ready before the edge, then update the model and check outputs.
  task automatic step(input string tag);
    logic        hz, exp_rdy, iss, cons;
    logic [31:0] np;
    txn_t        t, f;
    @(negedge clk);
    hz = (m_pend[in_sa] && !hit(in_sa)) ||
         (!in_useImm && m_pend[in_sb] && !hit(in_sb)) ||
         (in_regWrite && m_pend[in_da] && !hit(in_da));
    exp_rdy = !hz && (!m_valid || out_ready);
    if (!reset) check_val({tag, ":in_ready"}, {63'd0, in_ready}, {63'd0, exp_rdy});
    check_val({tag, ":rdAddrA"}, {59'd0, rdAddrA}, {59'd0, in_sa});
    check_val({tag, ":rdAddrB"}, {59'd0, rdAddrB}, {59'd0, in_sb});
    iss  = in_valid && exp_rdy && !reset;
    cons = m_valid && out_ready;
    t.a  = model_opnd(in_sa, rdDataA);
    t.b  = in_useImm ? in_imm : model_opnd(in_sb, rdDataB);
    t.da = in_da;
    t.rw = in_regWrite;
    np = m_pend;
    if (wb_write) np[wb_addr] = 1'b0;
    if (iss && in_regWrite) np[in_da] = 1'b1;
    np[31] = 1'b0;
    @(posedge clk);
    #1;
    if (reset) begin
      m_pend = 32'd0;
      m_valid = 1'b0;
      exp_q.delete();
      check_val({tag, ":rst_out_a"}, out_a, 64'd0);
      check_val({tag, ":rst_out_b"}, out_b, 64'd0);
      check_val({tag, ":rst_out_da"}, {59'd0, out_da}, 64'd0);
      check_val({tag, ":rst_out_rw"}, {63'd0, out_regWrite}, 64'd0);
    end else begin
      if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
      if (iss) exp_q.push_back(t);
      m_valid = iss ? 1'b1 : (out_ready ? 1'b0 : m_valid);
      m_pend  = np;
    end
    check_val({tag, ":out_valid"}, {63'd0, out_valid}, {63'd0, m_valid});
    check_val({tag, ":pending"}, {32'd0, dut.pending}, {32'd0, m_pend});
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check_val({tag, ":queue_empty"}, 64'd0, 64'd1);
      end else begin
        f = exp_q[0];
        check_val({tag, ":out_a"}, out_a, f.a);
        check_val({tag, ":out_b"}, out_b, f.b);
        check_val({tag, ":out_da"}, {59'd0, out_da}, {59'd0, f.da});
        check_val({tag, ":out_rw"}, {63'd0, out_regWrite}, {63'd0, f.rw});
      end
    end
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1; rdDataA = 64'd0; rdDataB = 64'd0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0);
    set_wb(1'b0, 5'd0, 64'd0);
    step("rst0");
    step("rst1");
    reset = 1'b0;

    // Basic issue with read data and pending set on destination.
    rdDataA = 64'd5; rdDataB = 64'd7;
    set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 64'd0);
    step("basic");

    // RAW stall on r3, then resolved by same-cycle writeback bypass.
    set_in(1'b1, 5'd3, 5'd2, 5'd6, 1'b0, 1'b0, 64'd0);
    step("raw_stall");
    set_wb(1'b1, 5'd3, 64'hAAAA);
    step("raw_bypass");
    set_wb(1'b0, 5'd0, 64'd0);

    // Zero register reads 0 and is never tracked.
    rdDataA = 64'hFFFF;
    set_in(1'b1, 5'd31, 5'd2, 5'd31, 1'b1, 1'b0, 64'd0);
    step("zero_reg");

    // Downstream backpressure holds the output slot, then releases.
    out_ready = 1'b0;
    rdDataA = 64'h11; rdDataB = 64'h22;
    set_in(1'b1, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 64'd0);
    step("hold0");
    step("hold1");
    out_ready = 1'b1;
    step("release");

    // Same-cycle writeback and re-issue of r4 leaves r4 pending.
    set_in(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 64'd0);
    step("set_r4");
    set_wb(1'b1, 5'd4, 64'h44);
    step("wb_and_set_r4");
    set_wb(1'b0, 5'd0, 64'd0);

    // WAW stall, then immediate operand skips the B-source hazard.
    set_in(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 64'd0);
    step("waw_stall");
    set_in(1'b1, 5'd0, 5'd4, 5'd8, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0);
    step("imm_skip");

    // Reset in the middle of a stall discards everything.
    set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 64'd0);
    step("set_r3");
    out_ready = 1'b0;
    set_in(1'b1, 5'd3, 5'd0, 5'd9, 1'b0, 1'b0, 64'd0);
    step("stall_r3");
    reset = 1'b1;
    step("mid_rst");
    reset = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 5'd3, 5'd0, 5'd9, 1'b0, 1'b0, 64'd0);
    step("post_rst");

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 3) != 0),
             ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
             {$urandom, $urandom});
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      rdDataA   = {$urandom, $urandom};
      rdDataB   = {$urandom, $urandom};
      out_ready = 1'($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
